// File: rtl/stopwatch_defs.sv
// Shared state encodings for the multi-lap stopwatch.
package stopwatch_defs;
   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUNNING = 2'd1,
      ST_EXPIRED = 2'd2
   } sw_state_t;
endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick; holds its count while disabled.
module tick_prescaler #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign tick = enable && (count == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end
endmodule

// File: rtl/multi_lap_stopwatch.sv
// Up/down stopwatch with a small lap memory and stepped readback.
module multi_lap_stopwatch
   import stopwatch_defs::*;
#(
   parameter int CLOCK_FREQ = 50000000,
   parameter int TICK_HZ    = 10,
   parameter int WIDTH      = 16,
   parameter int LAP_AW     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_stop,
   input  logic              lap,
   input  logic              show_next,
   input  logic              load,
   input  logic              down_mode,
   input  logic [WIDTH-1:0]  preset,
   output logic [WIDTH-1:0]  elapsed,
   output logic [WIDTH-1:0]  lap_value,
   output logic [LAP_AW-1:0] lap_index,
   output logic [LAP_AW:0]   lap_count,
   output logic              running,
   output logic              done,
   output logic              overflow
);
   localparam int DIV = CLOCK_FREQ / TICK_HZ;
   localparam int LAP_DEPTH = 1 << LAP_AW;
   localparam logic [LAP_AW:0] FULL = (LAP_AW + 1)'(LAP_DEPTH);

   sw_state_t        state;
   logic             mode_down;
   logic             tick;
   logic             is_run;
   logic             pre_clear;
   logic [LAP_AW:0]  next_index;
   logic [WIDTH-1:0] mem [LAP_DEPTH];

   assign is_run     = (state == ST_RUNNING);
   assign running    = is_run;
   assign done       = (state == ST_EXPIRED);
   assign pre_clear  = load && !start_stop && !is_run;
   assign next_index = {1'b0, lap_index} + 1'b1;

   tick_prescaler #(
      .DIV(DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (pre_clear),
      .enable(is_run),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_STOPPED;
         mode_down <= 1'b0;
         elapsed   <= '0;
         lap_value <= '0;
         lap_index <= '0;
         lap_count <= '0;
         overflow  <= 1'b0;
         for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
      end else begin
         lap_value <= mem[lap_index];

         // The tick is honoured even on the edge that stops the count.
         if (is_run && tick) begin
            if (mode_down) begin
               elapsed <= elapsed - 1'b1;
               if (elapsed == WIDTH'(1)) state <= ST_EXPIRED;
            end else if (elapsed == '1) begin
               overflow <= 1'b1;
            end else begin
               elapsed <= elapsed + 1'b1;
            end
         end

         if (start_stop) begin
            case (state)
               ST_STOPPED: begin
                  if (!(down_mode && elapsed == '0)) begin
                     state     <= ST_RUNNING;
                     mode_down <= down_mode;
                     lap_index <= '0;
                  end
               end
               default: state <= ST_STOPPED;
            endcase
         end else if (load) begin
            if (!is_run) begin
               state     <= ST_STOPPED;
               elapsed   <= preset;
               lap_count <= '0;
               lap_index <= '0;
               overflow  <= 1'b0;
               for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
            end
         end else if (lap) begin
            if (is_run && lap_count < FULL) begin
               mem[lap_count[LAP_AW-1:0]] <= elapsed;
               lap_count <= lap_count + 1'b1;
            end
         end else if (show_next) begin
            if (!is_run) begin
               if (lap_count == '0 || next_index >= lap_count)
                  lap_index <= '0;
               else
                  lap_index <= lap_index + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_multi_lap_stopwatch.sv
// Directed bench for multi_lap_stopwatch with a 10-cycle tick.
module tb_multi_lap_stopwatch;
   logic       clk = 1'b0;
   logic       reset, start_stop, lap, show_next, load, down_mode;
   logic [7:0] preset;
   logic [7:0] elapsed, lap_value;
   logic [1:0] lap_index;
   logic [2:0] lap_count;
   logic       running, done, overflow;

   int n_checks = 0;
   int n_fail = 0;

   multi_lap_stopwatch #(
      .CLOCK_FREQ(100),
      .TICK_HZ   (10),
      .WIDTH     (8),
      .LAP_AW    (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start_stop(start_stop),
      .lap       (lap),
      .show_next (show_next),
      .load      (load),
      .down_mode (down_mode),
      .preset    (preset),
      .elapsed   (elapsed),
      .lap_value (lap_value),
      .lap_index (lap_index),
      .lap_count (lap_count),
      .running   (running),
      .done      (done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the pulse covers exactly the next rising edge.
   task automatic pulse(input bit ss, input bit ld, input bit lp,
                        input bit sn);
      start_stop = ss;
      load = ld;
      lap = lp;
      show_next = sn;
      @(negedge clk);
      start_stop = 0;
      load = 0;
      lap = 0;
      show_next = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1; start_stop = 0; lap = 0; show_next = 0;
      load = 0; down_mode = 0; preset = 0;
      cycles(2);
      reset = 0;
      check("rst_elapsed", 32'(elapsed), 0);
      check("rst_running", 32'(running), 0);
      check("rst_done", 32'(done), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_lap_count", 32'(lap_count), 0);
      check("rst_lap_index", 32'(lap_index), 0);
      check("rst_lap_value", 32'(lap_value), 0);

      // Up count: 36 running edges -> 3 ticks
      pulse(1, 0, 0, 0);
      check("up_running", 32'(running), 1);
      cycles(35);
      pulse(1, 0, 0, 0);
      check("up_elapsed", 32'(elapsed), 3);
      check("up_stopped", 32'(running), 0);

      // Laps: fresh prescaler, laps on edges 30, 45, 65, 85, 95
      preset = 0;
      pulse(0, 1, 0, 0);
      check("ld0_elapsed", 32'(elapsed), 0);
      pulse(1, 0, 0, 0);
      cycles(29);
      pulse(0, 0, 1, 0);
      check("lap_on_tick_elapsed", 32'(elapsed), 3);
      check("lap_count1", 32'(lap_count), 1);
      cycles(14);
      pulse(0, 0, 1, 0);
      cycles(19);
      pulse(0, 0, 1, 0);
      cycles(19);
      pulse(0, 0, 1, 0);
      check("lap_count4", 32'(lap_count), 4);
      cycles(9);
      pulse(0, 0, 1, 0);
      check("lap_full_drop", 32'(lap_count), 4);
      pulse(1, 0, 0, 0);
      check("lap_stop_elapsed", 32'(elapsed), 9);
      check("lap_stop_running", 32'(running), 0);
      check("lap_idx0", 32'(lap_index), 0);
      check("lap_val0", 32'(lap_value), 2);
      pulse(0, 0, 0, 1);
      cycles(1);
      check("lap_idx1", 32'(lap_index), 1);
      check("lap_val1", 32'(lap_value), 4);
      pulse(0, 0, 0, 1);
      cycles(1);
      check("lap_val2", 32'(lap_value), 6);
      pulse(0, 0, 0, 1);
      cycles(1);
      check("lap_idx3", 32'(lap_index), 3);
      check("lap_val3", 32'(lap_value), 8);
      pulse(0, 0, 0, 1);
      cycles(1);
      check("lap_wrap_idx", 32'(lap_index), 0);
      check("lap_wrap_val", 32'(lap_value), 2);

      // Countdown from 3
      preset = 3;
      pulse(0, 1, 0, 0);
      check("ld_clears_laps", 32'(lap_count), 0);
      cycles(1);
      check("ld_clears_mem", 32'(lap_value), 0);
      down_mode = 1;
      pulse(1, 0, 0, 0);
      cycles(29);
      check("dn_elapsed_29", 32'(elapsed), 1);
      check("dn_not_done", 32'(done), 0);
      cycles(1);
      check("dn_done", 32'(done), 1);
      check("dn_elapsed_0", 32'(elapsed), 0);
      check("dn_not_running", 32'(running), 0);
      pulse(1, 0, 0, 0);
      check("dn_ack", 32'(done), 0);
      pulse(1, 0, 0, 0);
      check("dn_zero_nostart", 32'(running), 0);

      // Saturation at 255
      down_mode = 0;
      preset = 254;
      pulse(0, 1, 0, 0);
      pulse(1, 0, 0, 0);
      cycles(25);
      check("sat_elapsed", 32'(elapsed), 255);
      check("sat_overflow", 32'(overflow), 1);
      preset = 7;
      pulse(0, 1, 0, 0);
      cycles(4);
      check("ld_run_ignored", 32'(elapsed), 255);
      check("sat_still_run", 32'(running), 1);
      pulse(1, 0, 0, 0);
      preset = 5;
      pulse(0, 1, 0, 0);
      check("ld_clr_overflow", 32'(overflow), 0);
      check("ld_elapsed5", 32'(elapsed), 5);

      // Priority: start_stop beats load
      pulse(1, 0, 0, 0);
      cycles(12);
      preset = 99;
      pulse(1, 1, 0, 0);
      check("prio_stopped", 32'(running), 0);
      check("prio_elapsed", 32'(elapsed), 6);

      // Resume from held prescaler (count 3), then reset mid-run
      pulse(1, 0, 0, 0);
      cycles(9);
      pulse(0, 0, 1, 0);
      cycles(10);
      check("res_elapsed", 32'(elapsed), 8);
      check("res_lap_count", 32'(lap_count), 1);
      check("res_lap_value", 32'(lap_value), 7);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("mid_rst_elapsed", 32'(elapsed), 0);
      check("mid_rst_running", 32'(running), 0);
      check("mid_rst_lap_count", 32'(lap_count), 0);
      check("mid_rst_lap_value", 32'(lap_value), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_overflow", 32'(overflow), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
